skip_slice_sequencer: RTL

//  Captures one 16-lane x 16-bit skip-connection vector from the layer buffer and

---
 rtl/skip_slice_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/skip_slice_sequencer.sv
// Purpose : capture one LANES x DATA_W skip vector and stream it as SLICE-lane beats,
//           PASSES sweeps per capture, with the matching {pass, group code} depth select.
// Latency : first beat valid the cycle after capture; GROUPS*PASSES beats per frame.
// Backpr. : a beat holds (data, depth_sel, last_slice) while skip_out_ready is low;
//           a new vector is taken only in IDLE or on acceptance of the final beat.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   skip_in / _valid / _ready    full skip vector in, lane k at [k*DATA_W +: DATA_W]
//   skip_out / _valid / _ready   current slice (lanes g*SLICE .. g*SLICE+SLICE-1)
//   depth_sel                    {pass[0], code}, code = 01,10,11,00 for group 0..3
//   last_slice                   current beat is the final beat of the final pass
//   busy                         streaming a frame
//   frame_done                   one-cycle pulse after the final beat is accepted
module skip_slice_sequencer #(
  parameter int DATA_W = 16,
  parameter int LANES  = 16,
  parameter int SLICE  = 4,
  parameter int PASSES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES*DATA_W-1:0]   skip_in,
  input  logic                      skip_in_valid,
  output logic                      skip_in_ready,
  output logic [SLICE*DATA_W-1:0]   skip_out,
  output logic                      skip_out_valid,
  input  logic                      skip_out_ready,
  output logic [2:0]                depth_sel,
  output logic                      last_slice,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int GROUPS = LANES / SLICE;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                    state_q, state_d;
  logic [GW-1:0]             group_q, group_d;
  logic                      pass_q, pass_d;
  logic [LANES*DATA_W-1:0]   held_q, held_d;
  logic                      frame_done_q, frame_done_d;
  logic                      last_group;
  logic [1:0]                code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      group_q      <= '0;
      pass_q       <= 1'b0;
      held_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      group_q      <= group_d;
      pass_q       <= pass_d;
      held_q       <= held_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign last_group = (group_q == GW'(GROUPS - 1));
  // Group code rotates 01,10,11,00 so group 0 never drives the mux's 00 input.
  assign code       = last_group ? 2'b00 : 2'(group_q + GW'(1));

  assign busy           = (state_q == STREAM);
  assign skip_out_valid = busy;
  assign skip_out       = held_q[int'(group_q)*SLICE*DATA_W +: SLICE*DATA_W];
  assign depth_sel      = {pass_q, code};
  assign last_slice     = busy && last_group && (pass_q == 1'(PASSES - 1));
  assign frame_done     = frame_done_q;
  // Ready only depends on registered state and the downstream ready, never on skip_in_valid.
  assign skip_in_ready  = (state_q == IDLE) || (last_slice && skip_out_ready);

  always_comb begin
    state_d      = state_q;
    group_d      = group_q;
    pass_d       = pass_q;
    held_d       = held_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (skip_in_valid) begin
          held_d  = skip_in;
          group_d = '0;
          pass_d  = 1'b0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (skip_out_ready) begin
          if (last_slice) begin
            frame_done_d = 1'b1;
            group_d      = '0;
            pass_d       = 1'b0;
            // Back-to-back: take the next vector on the same edge, no idle bubble.
            if (skip_in_valid) held_d = skip_in;
            else               state_d = IDLE;
          end else if (last_group) begin
            // Only reachable when PASSES==2, so pass simply flips 0 -> 1.
            group_d = '0;
            pass_d  = ~pass_q;
          end else begin
            group_d = group_q + GW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
